// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target and the TFP410 configuration initiator.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WRITE,
      WRITE_ACK,
      READ,
      READ_ACK,
      IGNORE
   } i2c_state_e;

   localparam logic I2C_RW_READ = 1'b1;
   localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_line_filter.sv
// SCL/SDA conditioning: two-flop synchronizer, FILTER_LEN glitch filter, and
// edge / START / STOP detection on the filtered levels.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clock,
   input  logic reset_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

   logic [1:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
   logic          scl_p_q, sda_p_q;
   logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

   // A level flips only after FILTER_LEN consecutive samples disagree with it.
   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_in};
      sda_sync_d = {sda_sync_q[0], sda_in};
      scl_f_d    = scl_f_q;
      sda_f_d    = sda_f_q;
      scl_cnt_d  = CNT_LOAD;
      sda_cnt_d  = CNT_LOAD;
      if (scl_sync_q[1] != scl_f_q) begin
         if (scl_cnt_q == '0) scl_f_d = scl_sync_q[1];
         else                 scl_cnt_d = scl_cnt_q - 1'b1;
      end
      if (sda_sync_q[1] != sda_f_q) begin
         if (sda_cnt_q == '0) sda_f_d = sda_sync_q[1];
         else                 sda_cnt_d = sda_cnt_q - 1'b1;
      end
   end

   // Reset to the idle-high bus so release of reset never looks like an edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_f_q    <= 1'b1;
         sda_f_q    <= 1'b1;
         scl_p_q    <= 1'b1;
         sda_p_q    <= 1'b1;
         scl_cnt_q  <= CNT_LOAD;
         sda_cnt_q  <= CNT_LOAD;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_f_q    <= scl_f_d;
         sda_f_q    <= sda_f_d;
         scl_p_q    <= scl_f_q;
         sda_p_q    <= sda_f_q;
         scl_cnt_q  <= scl_cnt_d;
         sda_cnt_q  <= sda_cnt_d;
      end
   end

   assign sda      = sda_f_q;
   assign scl_rise = scl_f_q & ~scl_p_q;
   assign scl_fall = ~scl_f_q & scl_p_q;
   assign start    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
   assign stop     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a small register file: pointer write, data writes and
// sequential reads, with the registers exposed as a flat bus.
//
// state     | meaning
// IDLE      | bus ignored until START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving ACK for our address
// PTR       | shifting in register pointer
// PTR_ACK   | driving ACK for pointer byte
// WRITE     | shifting in a data byte
// WRITE_ACK | byte committed, driving ACK
// READ      | driving 8 data bits from regs[pointer]
// READ_ACK  | sampling initiator ACK/NACK
// IGNORE    | not addressed or read ended, wait for START/STOP
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR   = 7'h38,
   parameter int         REG_COUNT  = 16,
   parameter int         FILTER_LEN = 3,
   localparam int        PW         = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   scl_in,
   input  logic                   sda_in,
   output logic                   sda_oe,
   output logic [REG_COUNT*8-1:0] regs,
   output logic                   wr_strobe,
   output logic [PW-1:0]          wr_index,
   output logic                   busy
);

   logic sda_f, scl_rise, scl_fall, start, stop;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clock    (clock),
      .reset_n  (reset_n),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda      (sda_f),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   i2c_state_e             state_q, state_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   ack_q, ack_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [REG_COUNT*8-1:0] regs_q, regs_d;
   logic                   oe_q, oe_d;
   logic                   busy_q, busy_d;
   logic                   wr_strobe_q, wr_strobe_d;
   logic [PW-1:0]          wr_index_q, wr_index_d;

   logic [7:0]    byte_in, rd_byte;
   logic [PW-1:0] ptr_inc;

   assign byte_in = {shift_q[6:0], sda_f};
   assign rd_byte = regs_q[{ptr_q, 3'b000} +: 8];
   assign ptr_inc = (ptr_q == PW'(REG_COUNT - 1)) ? '0 : ptr_q + PW'(1);

   // ack_q marks that the ACK bit's SCL rise has been seen, so the next fall ends it.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ack_d       = ack_q;
      ptr_d       = ptr_q;
      regs_d      = regs_q;
      oe_d        = oe_q;
      busy_d      = busy_q;
      wr_strobe_d = 1'b0;
      wr_index_d  = wr_index_q;
      if (start) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
         ack_d     = 1'b0;
         oe_d      = 1'b0;
         busy_d    = 1'b0;
      end else if (stop) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            ADDR, PTR, WRITE: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  ack_d     = 1'b0;
                  if (bit_cnt_q == 4'd7) begin
                     if (state_q == ADDR) begin
                        if (byte_in[7:1] == I2C_ADDR) begin
                           state_d = ADDR_ACK;
                           busy_d  = 1'b1;
                        end else begin
                           state_d = IGNORE;
                        end
                     end else if (state_q == PTR) begin
                        ptr_d   = PW'(32'(byte_in) % REG_COUNT);
                        state_d = PTR_ACK;
                     end else begin
                        state_d = WRITE_ACK;
                     end
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WRITE_ACK: begin
               if (scl_rise) begin
                  ack_d = 1'b1;
               end else if (scl_fall) begin
                  if (!ack_q) begin
                     oe_d = 1'b1;
                     if (state_q == WRITE_ACK) begin
                        regs_d[{ptr_q, 3'b000} +: 8] = shift_q;
                        wr_index_d  = ptr_q;
                        wr_strobe_d = 1'b1;
                        ptr_d       = ptr_inc;
                     end
                  end else begin
                     oe_d      = 1'b0;
                     ack_d     = 1'b0;
                     bit_cnt_d = '0;
                     if (state_q == ADDR_ACK && shift_q[0] == I2C_RW_READ) begin
                        state_d = READ;
                        shift_d = rd_byte;
                        oe_d    = ~rd_byte[7];
                        ptr_d   = ptr_inc;
                     end else if (state_q == ADDR_ACK) begin
                        state_d = PTR;
                     end else begin
                        state_d = WRITE;
                     end
                  end
               end
            end
            READ: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     oe_d    = 1'b0;
                     ack_d   = 1'b0;
                     state_d = READ_ACK;
                  end else begin
                     oe_d = ~shift_q[3'd7 - bit_cnt_q[2:0]];
                  end
               end
            end
            READ_ACK: begin
               if (scl_rise) begin
                  if (sda_f == I2C_ACK) ack_d = 1'b1;
                  else                  state_d = IGNORE;
               end else if (scl_fall && ack_q) begin
                  state_d   = READ;
                  bit_cnt_d = '0;
                  ack_d     = 1'b0;
                  shift_d   = rd_byte;
                  oe_d      = ~rd_byte[7];
                  ptr_d     = ptr_inc;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ack_q       <= 1'b0;
         ptr_q       <= '0;
         regs_q      <= '0;
         oe_q        <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_index_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ack_q       <= ack_d;
         ptr_q       <= ptr_d;
         regs_q      <= regs_d;
         oe_q        <= oe_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_index_q  <= wr_index_d;
      end
   end

   assign sda_oe    = oe_q;
   assign regs      = regs_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_index  = wr_index_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged initiator on a wired-AND SDA, table
// vectors, hand-written corner sequences and random transactions vs a model.
module tb_i2c_target_regs;

   localparam int Q = 10;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         scl = 1'b1;
   logic         m_sda = 1'b1;
   logic         bus_sda;
   logic         sda_oe, wr_strobe, busy;
   logic [127:0] regs;
   logic [3:0]   wr_index;

   assign bus_sda = m_sda & ~sda_oe;

   always #5 clock = ~clock;

   i2c_target_regs #(.I2C_ADDR(7'h38), .REG_COUNT(16), .FILTER_LEN(3)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .scl_in    (scl),
      .sda_in    (bus_sda),
      .sda_oe    (sda_oe),
      .regs      (regs),
      .wr_strobe (wr_strobe),
      .wr_index  (wr_index),
      .busy      (busy)
   );

   int n_pass = 0;
   int n_chk  = 0;
   int oe_cycles = 0;
   int strobe_q[$];
   int exp_strobes[$];
   logic [7:0] m_regs[16];
   int m_ptr = 0;

   always @(negedge clock) begin
      if (sda_oe) oe_cycles++;
      if (wr_strobe) strobe_q.push_back(int'(wr_index));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic bit_clk(input logic b, output logic s);
      m_sda = b; tick(Q);
      scl = 1'b1; tick(Q);
      s = bus_sda; tick(Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic bit_clk_glitch(input logic b);
      m_sda = b; tick(Q);
      scl = 1'b1; tick(Q);
      m_sda = ~b; tick(1);
      m_sda = b; tick(Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; tick(Q);
      scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(Q);
      scl = 1'b1; tick(Q);
      m_sda = 1'b1; tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--) bit_clk(d[i], s);
      bit_clk(1'b1, s);
      acked = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_clk(1'b1, s);
         d[i] = s;
      end
      bit_clk(nack, s);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] p, input logic [7:0] dq[$],
                           output int nacks);
      logic ack;
      nacks = 0;
      i2c_start();
      send_byte({a, 1'b0}, ack); if (!ack) nacks++;
      send_byte(p, ack);         if (!ack) nacks++;
      foreach (dq[i]) begin
         send_byte(dq[i], ack);
         if (!ack) nacks++;
      end
      i2c_stop();
   endtask

   task automatic do_read(input logic [7:0] p, input int n, output logic [7:0] rq[$], output int nacks);
      logic ack;
      logic [7:0] d;
      nacks = 0;
      rq = {};
      i2c_start();
      send_byte(8'h70, ack); if (!ack) nacks++;
      send_byte(p, ack);     if (!ack) nacks++;
      i2c_start();
      send_byte(8'h71, ack); if (!ack) nacks++;
      for (int i = 0; i < n; i++) begin
         read_byte(i == n - 1, d);
         rq.push_back(d);
      end
      i2c_stop();
   endtask

   task automatic model_write(input logic [7:0] p, input logic [7:0] dq[$]);
      m_ptr = int'(p) % 16;
      foreach (dq[i]) begin
         m_regs[m_ptr] = dq[i];
         exp_strobes.push_back(m_ptr);
         m_ptr = (m_ptr + 1) % 16;
      end
   endtask

   task automatic model_reset();
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_ptr = 0;
   endtask

   task automatic check_regs(input string name);
      int bad = 0;
      for (int i = 0; i < 16; i++) if (regs[i*8 +: 8] !== m_regs[i]) bad++;
      check(name, bad, 0);
   endtask

   task automatic check_strobes(input string name);
      check({name, "_cnt"}, strobe_q.size(), exp_strobes.size());
      for (int i = 0; i < exp_strobes.size() && i < strobe_q.size(); i++)
         check({name, "_idx"}, strobe_q[i], exp_strobes[i]);
      strobe_q.delete();
      exp_strobes.delete();
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] ptr;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       exp_ack;
      int         ia;
      logic [7:0] va;
      int         ib;
      logic [7:0] vb;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic [7:0] dq[$];
      logic [7:0] rq[$];
      logic [7:0] d;
      logic ack, s;
      int nacks;

      vecs[0] = '{8'h70, 8'h05, 8'hA5, 8'h3C, 1'b1,  5, 8'hA5, 6, 8'h3C};
      vecs[1] = '{8'h70, 8'h0F, 8'h11, 8'h22, 1'b1, 15, 8'h11, 0, 8'h22};
      vecs[2] = '{8'h72, 8'h03, 8'h77, 8'h88, 1'b0,  3, 8'h00, 4, 8'h00};
      vecs[3] = '{8'h70, 8'h25, 8'h01, 8'h02, 1'b1,  5, 8'h01, 6, 8'h02};

      model_reset();
      tick(3);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_regs_zero", regs == 128'd0, 1);
      check("rst_wr_strobe", wr_strobe, 0);
      check("rst_wr_index", wr_index, 0);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      tick(5);

      foreach (vecs[k]) begin
         strobe_q.delete();
         exp_strobes.delete();
         oe_cycles = 0;
         dq = {};
         dq.push_back(vecs[k].d0);
         dq.push_back(vecs[k].d1);
         do_write(vecs[k].addr[7:1], vecs[k].ptr, dq, nacks);
         check("vec_nacks", nacks, vecs[k].exp_ack ? 0 : 4);
         check("vec_busy_after_stop", busy, 0);
         check("vec_reg_a", regs[vecs[k].ia*8 +: 8], vecs[k].va);
         check("vec_reg_b", regs[vecs[k].ib*8 +: 8], vecs[k].vb);
         check("vec_strobe_cnt", strobe_q.size(), vecs[k].exp_ack ? 2 : 0);
         if (vecs[k].exp_ack) begin
            check("vec_strobe_idx0", strobe_q.size() > 0 ? strobe_q[0] : -1, vecs[k].ia);
            check("vec_strobe_idx1", strobe_q.size() > 1 ? strobe_q[1] : -1, vecs[k].ib);
            model_write(vecs[k].ptr, dq);
         end else begin
            check("vec_no_drive", oe_cycles, 0);
         end
      end
      strobe_q.delete();
      exp_strobes.delete();

      // Pointer write, repeated START, two-byte read ending in NACK.
      dq = {};
      dq.push_back(8'h5A);
      dq.push_back(8'hC3);
      do_write(7'h38, 8'h02, dq, nacks);
      model_write(8'h02, dq);
      check("pre_nacks", nacks, 0);
      i2c_start();
      send_byte(8'h70, ack);
      check("rd_addr_ack", ack, 1);
      check("rd_busy_after_match", busy, 1);
      send_byte(8'h02, ack);
      i2c_start();
      send_byte(8'h71, ack);
      check("rd_raddr_ack", ack, 1);
      read_byte(1'b0, d);
      check("rd_byte0", d, 8'h5A);
      read_byte(1'b1, d);
      check("rd_byte1", d, 8'hC3);
      oe_cycles = 0;
      tick(2 * Q);
      check("rd_released_after_nack", oe_cycles, 0);
      i2c_stop();
      check("rd_busy_after_stop", busy, 0);
      check_strobes("rd_strobes");

      // Glitches on SDA while SCL high, then STOP cutting a data byte.
      dq = {};
      dq.push_back(8'h96);
      do_write(7'h38, 8'h08, dq, nacks);
      model_write(8'h08, dq);
      check_strobes("gl_pre");
      i2c_start();
      send_byte(8'h70, ack);
      send_byte(8'h08, ack);
      bit_clk_glitch(1'b0);
      bit_clk_glitch(1'b1);
      check("gl_no_false_start_stop", busy, 1);
      bit_clk(1'b0, s);
      bit_clk(1'b1, s);
      i2c_stop();
      check("gl_busy_after_stop", busy, 0);
      check("gl_reg8_kept", regs[8*8 +: 8], 8'h96);
      check_regs("gl_regs");
      check_strobes("gl_strobes");

      // Reset in the middle of a read while the target pulls SDA low.
      i2c_start();
      send_byte(8'h70, ack);
      send_byte(8'h02, ack);
      i2c_start();
      send_byte(8'h71, ack);
      check("rs_driving_zero", sda_oe, 1);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("rs_async_oe", sda_oe, 0);
      check("rs_regs_zero", regs == 128'd0, 1);
      check("rs_busy", busy, 0);
      scl = 1'b1;
      m_sda = 1'b1;
      tick(4);
      reset_n = 1'b1;
      tick(5);
      model_reset();
      strobe_q.delete();
      exp_strobes.delete();
      dq = {};
      dq.push_back(8'hE1);
      do_write(7'h38, 8'h04, dq, nacks);
      model_write(8'h04, dq);
      check("rs_post_nacks", nacks, 0);
      do_read(8'h04, 1, rq, nacks);
      check("rs_post_read", rq[0], 8'hE1);
      check_regs("rs_regs");
      check_strobes("rs_strobes");

      // Random transactions against the model.
      for (int t = 0; t < 12; t++) begin
         int kind, n;
         logic [7:0] p;
         logic [6:0] a;
         kind = $urandom_range(0, 2);
         n = $urandom_range(1, 3);
         p = 8'($urandom_range(0, 255));
         dq = {};
         for (int i = 0; i < n; i++) dq.push_back(8'($urandom_range(0, 255)));
         oe_cycles = 0;
         if (kind == 0) begin
            do_write(7'h38, p, dq, nacks);
            model_write(p, dq);
            check("rnd_wr_nacks", nacks, 0);
         end else if (kind == 1) begin
            do_read(p, n, rq, nacks);
            check("rnd_rd_nacks", nacks, 0);
            m_ptr = int'(p) % 16;
            for (int i = 0; i < n; i++) begin
               check("rnd_rd_data", i < rq.size() ? rq[i] : 8'hxx, m_regs[m_ptr]);
               m_ptr = (m_ptr + 1) % 16;
            end
         end else begin
            a = 7'($urandom_range(0, 127));
            if (a == 7'h38) a = 7'h39;
            do_write(a, p, dq, nacks);
            check("rnd_other_nacks", nacks, 2 + n);
            check("rnd_other_no_drive", oe_cycles, 0);
         end
         check_regs("rnd_regs");
         check_strobes("rnd_strobes");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
